vga_sync_generator: RTL



---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 30 +++
 rtl/vga_sync_generator.sv | 79 +++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator and the pixel generator.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int VGA_H_VISIBLE = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_VISIBLE = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;

   localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   typedef logic [CNT_W-1:0] cnt_t;

   // Half-open window test [lo, hi) used for both sync decodes.
   function automatic logic in_window(input cnt_t c, input int lo, input int hi);
      return (int'(c) >= lo) && (int'(c) < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-N counter with enable; exposes the next value so callers can decode ahead of the edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int N = VGA_H_TOTAL,
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic [W-1:0] nxt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   assign wrap = en && (count == LAST);

   always_comb begin
      nxt = count;
      if (en) nxt = (count == LAST) ? '0 : count + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else     count <= nxt;
   end

endmodule

// File: rtl/vga_sync_generator.sv
// Raster counters and sync pulses for VGA; VGA_SYNC_PIXEL_DIV_EN halves the pixel rate
// so a 50 MHz clk yields a 25 MHz scan.
module vga_sync_generator
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = VGA_H_VISIBLE,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_VISIBLE = VGA_V_VISIBLE,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   output logic [CNT_W-1:0] hCount,
   output logic [CNT_W-1:0] vCount,
   output logic             hsync,
   output logic             vsync,
   output logic             pixel_tick,
   output logic             line_start,
   output logic             frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_LO   = H_VISIBLE + H_FRONT;
   localparam int HS_HI   = HS_LO + H_SYNC;
   localparam int VS_LO   = V_VISIBLE + V_FRONT;
   localparam int VS_HI   = VS_LO + V_SYNC;

   logic       tick;
   logic       h_wrap, v_wrap;
   cnt_t       h_nxt, v_nxt;

   assign pixel_tick = tick;

   vga_axis_counter #(.N(H_TOTAL), .W(CNT_W)) u_h (
      .clk   (clk),
      .rst   (rst),
      .en    (tick),
      .count (hCount),
      .nxt   (h_nxt),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.N(V_TOTAL), .W(CNT_W)) u_v (
      .clk   (clk),
      .rst   (rst),
      .en    (h_wrap),
      .count (vCount),
      .nxt   (v_nxt),
      .wrap  (v_wrap)
   );

   // Syncs and pulses are decoded from the next count so they land on the same edge as the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick        <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
`ifdef VGA_SYNC_PIXEL_DIV_EN
         tick        <= ~tick;
`else
         tick        <= 1'b1;
`endif
         hsync       <= in_window(h_nxt, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
         vsync       <= in_window(v_nxt, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
         line_start  <= h_wrap;
         frame_start <= h_wrap && v_wrap;
      end
   end

endmodule
